sata_fis_receiver: RTL and testbench

Parametrised successor to the basic FIS extractor in the SATA link receive path. Sits between the descrambler output and the transport layer. Frames the incoming dword stream on SOF/EOF and skips in-frame primitives. Strips and checks the trailing CRC dword, enforces a maximum FIS length, and reports SYNC/SOF aborts. Every started frame produces exactly one beat flagged end-of-packet, so the transport layer always gets a closing status.

---
 rtl/sata_fis_receiver.sv | 174 +++++++++++++++++
 tb/tb_sata_fis_receiver.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_fis_receiver.sv
// SATA link-layer FIS receiver: frames descrambled dwords on SOF/EOF, strips and checks the
// trailing CRC dword, bounds the FIS length and closes every started frame with one eop beat.
module sata_fis_receiver #(
    parameter int unsigned MAX_DWORDS = 2049,
    parameter int          CRC_CHECK  = 1,
    parameter logic [31:0] CRC_INIT   = 32'h52325032
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rx_data,
    input  logic        rx_datak,
    output logic [31:0] fis_dat,
    output logic        fis_val,
    output logic        fis_sop,
    output logic        fis_eop,
    output logic        fis_crc_err,
    output logic        fis_abort
);
    localparam logic        DWORD_IS_PRIM = 1'b1;
    localparam logic        DWORD_IS_DATA = 1'b0;
    localparam logic [31:0] SOF_PRIM      = 32'h3737B57C;
    localparam logic [31:0] EOF_PRIM      = 32'hD5D5B57C;
    localparam logic [31:0] SYNC_PRIM     = 32'hB5B5957C;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam int          CNT_W         = $clog2(MAX_DWORDS + 2);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t           state_q, state_d;
    logic [31:0]      hold1, hold1_d, hold2, hold2_d, crc_reg, crc_d;
    logic             hold1_vld, hold1_vld_d, hold2_vld, hold2_vld_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             sop_pend, sop_pend_d;
    logic             beat_val, beat_sop, beat_eop, beat_crc_err, beat_abort;
    logic [31:0]      beat_dat;
    logic             close_abort, end_frame, start_frame;
    logic             is_data, is_sof, is_eof, is_sync;

    function automatic logic [31:0] crc_dword(input logic [31:0] crc_in, input logic [31:0] d);
        logic [31:0] c;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            if (c[31] ^ d[i]) c = (c << 1) ^ CRC_POLY;
            else              c = c << 1;
        end
        return c;
    endfunction

    assign is_data = (rx_datak == DWORD_IS_DATA);
    assign is_sof  = (rx_datak == DWORD_IS_PRIM) && (rx_data == SOF_PRIM);
    assign is_eof  = (rx_datak == DWORD_IS_PRIM) && (rx_data == EOF_PRIM);
    assign is_sync = (rx_datak == DWORD_IS_PRIM) && (rx_data == SYNC_PRIM);

    always_comb begin
        state_d      = state_q;
        hold1_d      = hold1;
        hold2_d      = hold2;
        hold1_vld_d  = hold1_vld;
        hold2_vld_d  = hold2_vld;
        crc_d        = crc_reg;
        cnt_d        = cnt;
        sop_pend_d   = sop_pend;
        beat_val     = 1'b0;
        beat_sop     = 1'b0;
        beat_eop     = 1'b0;
        beat_crc_err = 1'b0;
        beat_abort   = 1'b0;
        beat_dat     = hold2;
        close_abort  = 1'b0;
        end_frame    = 1'b0;
        start_frame  = 1'b0;

        case (state_q)
            IDLE: begin
                start_frame = is_sof;
            end
            FRAME: begin
                if (is_data) begin
                    if (cnt == CNT_W'(MAX_DWORDS + 1)) begin
                        close_abort = 1'b1;
                        end_frame   = 1'b1;
                    end else begin
                        if (hold2_vld) begin
                            beat_val   = 1'b1;
                            beat_sop   = sop_pend;
                            sop_pend_d = 1'b0;
                        end
                        hold2_d     = hold1;
                        hold2_vld_d = hold1_vld;
                        if (hold1_vld) crc_d = crc_dword(crc_reg, hold1);
                        hold1_d     = rx_data;
                        hold1_vld_d = 1'b1;
                        cnt_d       = cnt + CNT_W'(1);
                    end
                end else if (is_eof) begin
                    if (hold2_vld) begin
                        beat_val     = 1'b1;
                        beat_sop     = sop_pend;
                        beat_eop     = 1'b1;
                        beat_crc_err = (CRC_CHECK != 0) && (hold1 != crc_reg);
                    end else begin
                        close_abort = 1'b1;
                    end
                    end_frame = 1'b1;
                end else if (is_sync) begin
                    close_abort = 1'b1;
                    end_frame   = 1'b1;
                end else if (is_sof) begin
                    close_abort = 1'b1;
                    start_frame = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A runt (hold2 empty) closes with a zero dword that is also the frame's first beat
        if (close_abort) begin
            beat_val   = 1'b1;
            beat_eop   = 1'b1;
            beat_abort = 1'b1;
            beat_sop   = hold2_vld ? sop_pend : 1'b1;
            beat_dat   = hold2_vld ? hold2 : 32'h0;
        end
        if (end_frame) begin
            state_d     = IDLE;
            hold1_vld_d = 1'b0;
            hold2_vld_d = 1'b0;
        end
        if (start_frame) begin
            state_d     = FRAME;
            hold1_vld_d = 1'b0;
            hold2_vld_d = 1'b0;
            cnt_d       = '0;
            crc_d       = CRC_INIT;
            sop_pend_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold1_vld   <= 1'b0;
            hold2_vld   <= 1'b0;
            cnt         <= '0;
            sop_pend    <= 1'b0;
            fis_val     <= 1'b0;
            fis_sop     <= 1'b0;
            fis_eop     <= 1'b0;
            fis_crc_err <= 1'b0;
            fis_abort   <= 1'b0;
            fis_dat     <= '0;
        end else begin
            state_q     <= state_d;
            hold1_vld   <= hold1_vld_d;
            hold2_vld   <= hold2_vld_d;
            cnt         <= cnt_d;
            sop_pend    <= sop_pend_d;
            fis_val     <= beat_val;
            fis_sop     <= beat_sop;
            fis_eop     <= beat_eop;
            fis_crc_err <= beat_crc_err;
            fis_abort   <= beat_abort;
            if (beat_val) fis_dat <= beat_dat;
        end
    end

    // Datapath holds and CRC are qualified by the valid bits, so they carry no reset
    always_ff @(posedge clk) begin
        hold1   <= hold1_d;
        hold2   <= hold2_d;
        crc_reg <= crc_d;
    end

endmodule

// File: tb/tb_sata_fis_receiver.sv
// Bench for sata_fis_receiver: three parameter variants share one stimulus stream and are
// compared every cycle against a frame-level model built from the payload list of each frame.
module tb_sata_fis_receiver;
    localparam logic [31:0] P_SOF   = 32'h3737B57C;
    localparam logic [31:0] P_EOF   = 32'hD5D5B57C;
    localparam logic [31:0] P_SYNC  = 32'hB5B5957C;
    localparam logic [31:0] P_HOLD  = 32'hD5D5AA7C;
    localparam logic [31:0] P_HOLDA = 32'h9595AA7C;
    localparam logic [31:0] P_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] P_CONT  = 32'h9999AA7C;
    localparam logic [31:0] P_RIP   = 32'h5555B57C;
    localparam logic [31:0] P_WTRM  = 32'h5858B57C;
    localparam logic        K_PRIM  = 1'b1;
    localparam logic        K_DATA  = 1'b0;
    localparam logic [31:0] POLY    = 32'h04C11DB7;
    localparam logic [31:0] SEED    = 32'h52325032;

    int maxd[3] = '{2049, 2049, 4};
    int chk[3]  = '{1, 0, 1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rx_data = P_ALIGN;
    logic        rx_datak = K_PRIM;
    logic [31:0] o_dat[3];
    logic        o_val[3], o_sop[3], o_eop[3], o_crc[3], o_abt[3];

    logic [31:0] fq[$];
    bit          inf[3];
    bit          n_val[3], e_val[3];
    logic [35:0] n_beat[3], e_beat[3];
    logic [35:0] cap0[$], cap1[$], cap2[$];
    logic [31:0] fr[$];
    bit          cmp_en = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    sata_fis_receiver #(.MAX_DWORDS(2049), .CRC_CHECK(1), .CRC_INIT(32'h52325032)) u0 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_datak(rx_datak),
        .fis_dat(o_dat[0]), .fis_val(o_val[0]), .fis_sop(o_sop[0]), .fis_eop(o_eop[0]),
        .fis_crc_err(o_crc[0]), .fis_abort(o_abt[0]));
    sata_fis_receiver #(.MAX_DWORDS(2049), .CRC_CHECK(0), .CRC_INIT(32'h52325032)) u1 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_datak(rx_datak),
        .fis_dat(o_dat[1]), .fis_val(o_val[1]), .fis_sop(o_sop[1]), .fis_eop(o_eop[1]),
        .fis_crc_err(o_crc[1]), .fis_abort(o_abt[1]));
    sata_fis_receiver #(.MAX_DWORDS(4), .CRC_CHECK(1), .CRC_INIT(32'h52325032)) u2 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_datak(rx_datak),
        .fis_dat(o_dat[2]), .fis_val(o_val[2]), .fis_sop(o_sop[2]), .fis_eop(o_eop[2]),
        .fis_crc_err(o_crc[2]), .fis_abort(o_abt[2]));

    function automatic logic [31:0] crc_dw(input logic [31:0] c_in, input logic [31:0] d);
        logic [31:0] c;
        c = c_in;
        for (int b = 31; b >= 0; b--) begin
            if (c[31] != d[b]) c = {c[30:0], 1'b0} ^ POLY;
            else               c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    // CRC over the first m dwords of the current frame
    function automatic logic [31:0] crc_upto(input int m);
        logic [31:0] c;
        c = SEED;
        for (int j = 0; j < m; j++) c = crc_dw(c, fq[j]);
        return c;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Closing beat of an aborted frame holding n data dwords
    task automatic abort_beat(input int i, input int n);
        n_val[i] = 1'b1;
        if (n >= 2) n_beat[i] = {(n == 2), 1'b1, 1'b0, 1'b1, fq[n-2]};
        else        n_beat[i] = {1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    endtask

    task automatic model(input logic k, input logic [31:0] d);
        int n = fq.size();
        bit is_data = (k == K_DATA);
        bit is_sof  = (k == K_PRIM) && (d == P_SOF);
        bit is_eof  = (k == K_PRIM) && (d == P_EOF);
        bit is_sync = (k == K_PRIM) && (d == P_SYNC);
        bit push    = is_data && inf[0] && (n != maxd[0] + 1);
        for (int i = 0; i < 3; i++) begin
            n_val[i]  = 1'b0;
            n_beat[i] = '0;
            if (inf[i]) begin
                if (is_data) begin
                    if (n == maxd[i] + 1) begin
                        abort_beat(i, n);
                        inf[i] = 1'b0;
                    end else if (n >= 2) begin
                        n_val[i]  = 1'b1;
                        n_beat[i] = {(n == 2), 3'b000, fq[n-2]};
                    end
                end else if (is_eof) begin
                    if (n >= 2) begin
                        n_val[i]  = 1'b1;
                        n_beat[i] = {(n == 2), 1'b1,
                                     (chk[i] != 0) && (fq[n-1] != crc_upto(n - 1)), 1'b0, fq[n-2]};
                    end else begin
                        abort_beat(i, n);
                    end
                    inf[i] = 1'b0;
                end else if (is_sync) begin
                    abort_beat(i, n);
                    inf[i] = 1'b0;
                end else if (is_sof) begin
                    abort_beat(i, n);
                end
            end
            if (is_sof) inf[i] = 1'b1;
        end
        if (is_sof)    fq.delete();
        else if (push) fq.push_back(d);
    endtask

    task automatic step(input logic k, input logic [31:0] d);
        rx_datak = k;
        rx_data  = d;
        model(k, d);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            e_val[i]  = n_val[i];
            e_beat[i] = n_beat[i];
        end
        #1;
    endtask

    task automatic prim(input logic [31:0] p);
        step(K_PRIM, p);
    endtask

    task automatic data(input logic [31:0] d);
        step(K_DATA, d);
    endtask

    task automatic gap();
        prim(P_HOLD); prim(P_ALIGN); prim(P_ALIGN); prim(P_CONT);
    endtask

    task automatic clear_caps();
        cap0.delete(); cap1.delete(); cap2.delete();
    endtask

    task automatic check_zero(input string nm);
        for (int i = 0; i < 3; i++)
            check($sformatf("%s_u%0d", nm, i),
                  64'({o_val[i], o_sop[i], o_eop[i], o_crc[i], o_abt[i], o_dat[i]}), 64'h0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_datak = K_PRIM;
        rx_data  = P_ALIGN;
        fq.delete();
        for (int i = 0; i < 3; i++) begin
            inf[i] = 1'b0; e_val[i] = 1'b0; e_beat[i] = '0;
        end
        #1;
        check_zero("reset_out");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] pl[$], input bit bad_crc, input bit gaps);
        logic [31:0] c = SEED;
        foreach (pl[j]) c = crc_dw(c, pl[j]);
        if (bad_crc) c[0] = ~c[0];
        prim(P_SOF);
        foreach (pl[j]) begin
            if (gaps) gap();
            data(pl[j]);
        end
        if (gaps) gap();
        data(c);
        if (gaps) gap();
        prim(P_EOF);
        prim(P_ALIGN);
        prim(P_ALIGN);
    endtask

    task automatic compare_cycle();
        if (!cmp_en) return;
        for (int i = 0; i < 3; i++) begin
            logic [35:0] got = {o_sop[i], o_eop[i], o_crc[i], o_abt[i], o_dat[i]};
            check($sformatf("val_u%0d", i), 64'(o_val[i]), 64'(e_val[i]));
            if (e_val[i]) check($sformatf("beat_u%0d", i), 64'(got), 64'(e_beat[i]));
            if (o_val[i]) begin
                case (i)
                    0:       cap0.push_back(got);
                    1:       cap1.push_back(got);
                    default: cap2.push_back(got);
                endcase
            end
        end
    endtask

    function automatic logic [31:0] rand_prim();
        case ($urandom_range(0, 5))
            0:       return P_HOLD;
            1:       return P_HOLDA;
            2:       return P_ALIGN;
            3:       return P_CONT;
            4:       return P_RIP;
            default: return P_WTRM;
        endcase
    endfunction

    task automatic run_random();
        for (int f = 0; f < 300; f++) begin
            int          nd = $urandom_range(0, 9);
            logic [31:0] c  = SEED;
            logic [31:0] d;
            repeat ($urandom_range(0, 2)) begin
                case ($urandom_range(0, 3))
                    0:       data($urandom);
                    1:       prim(P_EOF);
                    2:       prim(P_SYNC);
                    default: prim(rand_prim());
                endcase
            end
            prim(P_SOF);
            for (int j = 0; j < nd; j++) begin
                if ($urandom_range(0, 3) == 0) prim(rand_prim());
                if ($urandom_range(0, 39) == 0) prim(($urandom_range(0, 1) == 0) ? P_SYNC : P_SOF);
                d = $urandom;
                data(d);
                c = crc_dw(c, d);
            end
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                if (nd > 0 || $urandom_range(0, 1) == 0)
                    data(($urandom_range(0, 3) == 0) ? $urandom : c);
                if ($urandom_range(0, 3) == 0) prim(rand_prim());
                prim(P_EOF);
            end
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        check_zero("init_reset");
        reset  = 1'b0;
        cmp_en = 1'b1;

        check("crc_pin_data", 64'(crc_dw(32'h0, 32'h1)), 64'h04C11DB7);
        check("crc_pin_seed", 64'(crc_dw(32'h1, 32'h0)), 64'h04C11DB7);

        fr = '{32'h00EC8027, 32'h0, 32'h0, 32'h0, 32'h0};

        clear_caps();
        send_frame(fr, 1'b0, 1'b0);
        check("norm_count", 64'(cap0.size()), 64'd5);
        check("norm_first", 64'(cap0[0]), 64'({4'b1000, 32'h00EC8027}));
        check("norm_last", 64'(cap0[4]), 64'({4'b0100, 32'h0}));
        check("ovf_frame_count", 64'(cap2.size()), 64'd4);
        check("ovf_frame_last", 64'(cap2[3]), 64'({4'b0101, 32'h0}));

        clear_caps();
        send_frame(fr, 1'b0, 1'b1);
        check("gap_count", 64'(cap0.size()), 64'd5);
        check("gap_last", 64'(cap0[4]), 64'({4'b0100, 32'h0}));

        clear_caps();
        send_frame(fr, 1'b1, 1'b0);
        check("badcrc_last", 64'(cap0[4]), 64'({4'b0110, 32'h0}));
        check("nocheck_last", 64'(cap1[4]), 64'({4'b0100, 32'h0}));

        clear_caps();
        prim(P_SOF); data(32'hA0); data(32'hA1); data(32'hA2); prim(P_SYNC);
        prim(P_ALIGN); prim(P_ALIGN);
        check("sync_count", 64'(cap0.size()), 64'd2);
        check("sync_first", 64'(cap0[0]), 64'({4'b1000, 32'hA0}));
        check("sync_close", 64'(cap0[1]), 64'({4'b0101, 32'hA1}));

        clear_caps();
        prim(P_SOF); data(32'hB0); data(32'hB1); data(32'hB2);
        send_frame(fr, 1'b0, 1'b0);
        check("sof_count", 64'(cap0.size()), 64'd7);
        check("sof_close", 64'(cap0[1]), 64'({4'b0101, 32'hB1}));
        check("sof_next_first", 64'(cap0[2]), 64'({4'b1000, 32'h00EC8027}));
        check("sof_next_last", 64'(cap0[6]), 64'({4'b0100, 32'h0}));

        clear_caps();
        prim(P_SOF); prim(P_EOF); prim(P_ALIGN); prim(P_ALIGN);
        check("runt_count", 64'(cap0.size()), 64'd1);
        check("runt_beat", 64'(cap0[0]), 64'({4'b1101, 32'h0}));

        clear_caps();
        prim(P_SOF);
        for (int j = 0; j < 7; j++) data(32'h100 + 32'(j));
        prim(P_EOF); prim(P_ALIGN); prim(P_ALIGN);
        check("ovf_count", 64'(cap2.size()), 64'd4);
        check("ovf_first", 64'(cap2[0]), 64'({4'b1000, 32'h100}));
        check("ovf_close", 64'(cap2[3]), 64'({4'b0101, 32'h103}));

        prim(P_SOF); data(32'hC0); data(32'hC1); data(32'hC2); prim(P_ALIGN);
        clear_caps();
        do_reset();
        prim(P_ALIGN); prim(P_ALIGN);
        check("rst_no_beat", 64'(cap0.size()), 64'd0);
        send_frame(fr, 1'b0, 1'b0);
        check("rst_next_count", 64'(cap0.size()), 64'd5);
        check("rst_next_first", 64'(cap0[0]), 64'({4'b1000, 32'h00EC8027}));

        run_random();
        repeat (3) prim(P_ALIGN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
